// File: rtl/ctrl_word_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_word_pkg
// Shared definitions for the packed CPU control-word format.
//
// Word layout, MSB to LSB:
//   rsvd0[15] a[14:12] rsvd1[11] b[10:8] cin[7] c[6:4] rec[3:2]
//   pc_en[1] reg_en[0]
//
// Contents: bit-position constants for every field and reserved bit, field
// widths, and the decoded-field struct ctrl_fields_t.
// ---------------------------------------------------------------------------
package ctrl_word_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;

  // Field widths
  localparam int A_W      = 3;
  localparam int B_W      = 3;
  localparam int CIN_W    = 1;
  localparam int C_W      = 3;
  localparam int REC_W    = 2;
  localparam int PC_EN_W  = 1;
  localparam int REG_EN_W = 1;

  // Field LSB positions
  localparam int RSVD0_POS  = 15;
  localparam int A_LSB      = 12;
  localparam int RSVD1_POS  = 11;
  localparam int B_LSB      = 8;
  localparam int CIN_LSB    = 7;
  localparam int C_LSB      = 4;
  localparam int REC_LSB    = 2;
  localparam int PC_EN_LSB  = 1;
  localparam int REG_EN_LSB = 0;

  typedef struct packed {
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
    logic [CIN_W-1:0]    cin;
    logic [C_W-1:0]      c;
    logic [REC_W-1:0]    rec;
    logic [PC_EN_W-1:0]  pc_en;
    logic [REG_EN_W-1:0] reg_en;
  } ctrl_fields_t;

endpackage

// File: rtl/ctrl_fifo.sv
// ---------------------------------------------------------------------------
// ctrl_fifo
// Synchronous FIFO of 2^DEPTH_LOG2 entries with a combinational head.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; empties the FIFO
//   push   write wdata (ignored while full)
//   wdata  data to write
//   pop    discard the head entry (ignored while empty)
//   head   current head entry (valid while !empty)
//   full   no free entry
//   empty  no stored entry
// ---------------------------------------------------------------------------
module ctrl_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH[DEPTH_LOG2:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_word_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_word_decoder
// Unpacks 16-bit packed control words into individual datapath control
// fields. Words are buffered in ctrl_fifo and issued one per handshake from
// a registered, stallable output stage.
//
// Optional feature: define CTRL_WORD_RSVD_CHECK_EN to enable the sticky
// reserved-bit checker (rsvd_err / err_clr). Without it rsvd_err is 0.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/in_word/in_ready   input word stream
//   out_valid/out_ready         output handshake
//   out_a, out_b, out_cin, out_c, out_rec, out_pc_en, out_reg_en
//                    decoded fields, held stable while stalled
//   issued_cnt       wrapping count of output handshakes
//   err_clr          clears rsvd_err
//   rsvd_err         sticky reserved-bit error
// ---------------------------------------------------------------------------
module ctrl_word_decoder
  import ctrl_word_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_W-1:0]    out_a,
  output logic [B_W-1:0]    out_b,
  output logic              out_cin,
  output logic [C_W-1:0]    out_c,
  output logic [REC_W-1:0]  out_rec,
  output logic              out_pc_en,
  output logic              out_reg_en,
  output logic [CNT_W-1:0]  issued_cnt,
  input  logic              err_clr,
  output logic              rsvd_err
);

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] head;
  logic              push;
  logic              load;
  logic              issue;
  ctrl_fields_t      fields_p0;
  ctrl_fields_t      fields_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt;

  // in_ready comes from registered occupancy only; no write-through on full.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign issue    = vld_p1 && out_ready;
  assign load     = !fifo_empty && (!vld_p1 || out_ready);

  ctrl_fifo #(
    .DATA_W     (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_word),
    .pop   (load),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- stage p0: field decode of the FIFO head ----
  assign fields_p0.a      = head[A_LSB      +: A_W];
  assign fields_p0.b      = head[B_LSB      +: B_W];
  assign fields_p0.cin    = head[CIN_LSB    +: CIN_W];
  assign fields_p0.c      = head[C_LSB      +: C_W];
  assign fields_p0.rec    = head[REC_LSB    +: REC_W];
  assign fields_p0.pc_en  = head[PC_EN_LSB  +: PC_EN_W];
  assign fields_p0.reg_en = head[REG_EN_LSB +: REG_EN_W];

  // Reserved bits of the head are never decoded.
  logic unused_head_rsvd;
  assign unused_head_rsvd = head[RSVD0_POS] ^ head[RSVD1_POS];

  // ---- stage p1: output register and issue counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      fields_p1 <= '0;
      cnt       <= '0;
    end else begin
      if (load) begin
        vld_p1    <= 1'b1;
        fields_p1 <= fields_p0;
      end else if (issue) begin
        vld_p1 <= 1'b0;
      end
      if (issue) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_a      = fields_p1.a;
  assign out_b      = fields_p1.b;
  assign out_cin    = fields_p1.cin;
  assign out_c      = fields_p1.c;
  assign out_rec    = fields_p1.rec;
  assign out_pc_en  = fields_p1.pc_en;
  assign out_reg_en = fields_p1.reg_en;
  assign issued_cnt = cnt;

`ifdef CTRL_WORD_RSVD_CHECK_EN
  logic rsvd_hit;
  logic rsvd_err_q;

  // Checked on accepted input words, so the flag rises at the accept edge.
  assign rsvd_hit = push && (in_word[RSVD0_POS] || in_word[RSVD1_POS]);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsvd_err_q <= 1'b0;
    end else if (rsvd_hit) begin
      rsvd_err_q <= 1'b1;   // a new violation beats a same-edge clear
    end else if (err_clr) begin
      rsvd_err_q <= 1'b0;
    end
  end

  assign rsvd_err = rsvd_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign rsvd_err       = 1'b0;
`endif

endmodule

// File: doc/ctrl_word_decoder.md
# ctrl_word_decoder

Unpacks 16-bit packed CPU control words back into individual control fields for the datapath under test. It is the consuming end of the control-word format produced by the control-word packing register. Words arrive over a valid/ready stream and are buffered in a small FIFO. They are issued one per handshake through a registered output stage that the datapath can stall. An issue counter and an optional reserved-bit checker support bring-up.

## Interface
- DEPTH_LOG2, 2, FIFO depth is 2^DEPTH_LOG2 entries (legal 1..4)
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous and active-high
- in_valid  input  1  in_word is valid
- in_word  input  16  packed control word
- in_ready  output  1  FIFO can accept a word
- out_valid  output  1  decoded fields are valid
- out_ready  input  1  datapath consumes the current fields
- out_a  output  3  field a, from in_word[14:12]
- out_b  output  3  field b, from in_word[10:8]
- out_cin  output  1  carry-in, from in_word[7]
- out_c  output  3  field c, from in_word[6:4]
- out_rec  output  2  rec, from in_word[3:2]
- out_pc_en  output  1  PC enable, from in_word[1]
- out_reg_en  output  1  register-file enable, from in_word[0]
- issued_cnt  output  16  count of output handshakes
- err_clr  input  1  clears rsvd_err (only with the macro)
- rsvd_err  output  1  sticky reserved-bit error

## Operation
- Word layout, MSB to LSB:
  - rsvd0[15], a[14:12], rsvd1[11], b[10:8]
  - cin[7], c[6:4], rec[3:2], pc_en[1], reg_en[0]
- Input accept: a word is accepted on an edge when in_valid && in_ready. in_ready = !full.
- When the FIFO is full, in_ready is 0 even if the output stage is reading that cycle. There is no write-through-on-full.
- Output load: the output register loads the FIFO head on an edge when the FIFO is not empty and (!out_valid || out_ready). Fields are decoded from the head word at load time and held stable while out_valid && !out_ready.
- Output drain: if out_valid && out_ready and the FIFO is empty, out_valid falls at that edge.
- Issue count: issued_cnt increments by 1 on each edge with out_valid && out_ready. It wraps from 0xFFFF to 0x0000.
- Simultaneous events: a FIFO write and a FIFO read on the same edge leave the occupancy unchanged.
- FIFO pointers: DEPTH_LOG2-bit pointers that wrap naturally. Occupancy is held in a counter DEPTH_LOG2+1 bits wide.
- Reset (any cycle, including mid-stream):
  - FIFO is emptied and all buffered words are discarded.
  - out_valid=0 and every field output is 0.
  - issued_cnt=0 and rsvd_err=0.
  - in_ready=1 in the first cycle after reset is released.

## Timing
- Minimum latency: a word accepted at edge k, with the output stage free, is loaded at edge k+1. out_valid is high in the cycle after edge k+1.
- Throughput: one word per cycle sustained when out_ready is held at 1 and the FIFO is not empty.
- Empty FIFO: there is no combinational bypass. A word always passes through the FIFO.
- Combinational paths:
  - in_ready depends only on registered state.
  - There is no combinational path from out_ready to any output.

## Configuration
- Macro CTRL_WORD_RSVD_CHECK_EN, defined:
  - On an accepted word with in_word[15] or in_word[11] set, rsvd_err is set at that edge.
  - The word is still queued and issued normally.
  - rsvd_err stays set until err_clr=1 or reset.
  - If err_clr and a new violation occur on the same edge, the set wins.
- Macro undefined: rsvd_err is tied to 0 and err_clr is ignored.

## Structure
- Package ctrl_word_pkg holds:
  - Bit-position constants for every field and the two reserved bits.
  - Field width constants.
  - A packed struct typedef ctrl_fields_t for the decoded fields.
- Sub-module ctrl_fifo: a parameterised synchronous FIFO providing push, pop, head, full and empty.
- The decode logic, output register and counter live in ctrl_word_decoder.

## Test plan
- Basic decode: after reset, send 0x7FFF with out_ready=1.
  - Two edges later: a=7, b=7, cin=1, c=7, rec=3, pc_en=1, reg_en=1.
  - issued_cnt=1 after the handshake.
- Fill and stall: hold out_ready=0 and push 5 words with DEPTH_LOG2=2.
  - in_ready drops after 4 words are in the FIFO plus 1 in the output register.
  - Raise out_ready: all 5 words emerge in order on consecutive cycles.
- Stall hold: send 0x1234 with out_ready=0 for 10 cycles.
  - Fields stay a=1, b=2, cin=0, c=3, rec=1, pc_en=0, reg_en=0 throughout.
  - issued_cnt stays unchanged.
- Reset mid-stream: with 3 words buffered, pulse reset for 1 cycle.
  - Next cycle: out_valid=0, in_ready=1, issued_cnt=0.
  - No stale word is ever issued afterwards.
- Counter wrap: preload by issuing 65536 words.
  - issued_cnt returns to 0x0000 and then counts to 0x0001.
- Reserved bits (macro defined): send 0x8800.
  - rsvd_err=1 and the word is still issued with all fields 0.
  - err_clr=1 clears rsvd_err.
  - With the macro undefined, rsvd_err remains 0.
